// File: rtl/convacc_pkg.sv
// Shared types and sizing helpers for the sequential binary conv accumulator.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package convacc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_EMIT  = 2'd2
    } state_t;

    // Widest operand window the popcount helper handles.
    localparam int POPCNT_MAX_W = 256;

    // Accumulator width that holds a full pixel sum (IN_CH beats of WIN bits) without overflow.
    function automatic int f_acc_w(input int in_ch, input int win);
        return $clog2(in_ch * win + 1);
    endfunction

    // Packed map word width: one bit per output pixel.
    function automatic int f_map_w(input int out_dim);
        return out_dim * out_dim;
    endfunction

    // Index width for a counter over n values; never zero so ports stay legal.
    function automatic int f_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Number of set bits; callers zero-extend narrower vectors.
    function automatic int unsigned f_popcount(input logic [POPCNT_MAX_W-1:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < POPCNT_MAX_W; i++) begin
            c += {31'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/bin_popcnt.sv
// Counts the set bits of a WIN-bit vector (combinational adder tree).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; output follows input.
module bin_popcnt
    import convacc_pkg::*;
#(
    parameter int WIN = 25
) (
    input  logic [WIN-1:0]             vec,
    output logic [$clog2(WIN+1)-1:0]   cnt
);

    localparam int CNT_W = $clog2(WIN + 1);

    assign cnt = CNT_W'(f_popcount(POPCNT_MAX_W'(vec)));

endmodule

// File: rtl/convacc_bin_seq.sv
// Time-multiplexed binary conv accumulator: XNOR-popcount beats -> thresholded pixel bits -> one map word per output channel.
// Latency: o_valid 1 cycle after a channel's final beat (2 cycles with CONVACC_POPCNT_PIPE_EN defined, popcount registered).
// Backpressure: o_ready low while a map word waits in EMIT; the word is held stable until i_ready.
module convacc_bin_seq
    import convacc_pkg::*;
#(
    parameter int N_CH    = 60,
    parameter int IN_CH   = 18,
    parameter int WIN     = 25,
    parameter int OUT_DIM = 8,
    parameter int BW      = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [WIN-1:0]                i_act,
    input  logic [WIN-1:0]                i_wgt,
    input  logic [BW-1:0]                 i_thresh,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [f_map_w(OUT_DIM)-1:0]   o_map,
    output logic [f_idx_w(N_CH)-1:0]      o_ch,
    output logic                          o_last
);

    localparam int MAP_W  = f_map_w(OUT_DIM);
    localparam int PC_W   = $clog2(WIN + 1);
    localparam int ACC_W  = f_acc_w(IN_CH, WIN);
    localparam int CH_W   = f_idx_w(N_CH);
    localparam int PIX_W  = f_idx_w(MAP_W);
    localparam int BEAT_W = f_idx_w(IN_CH);

    state_t              state, state_nxt;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [PIX_W-1:0]    pix_cnt;
    logic [CH_W-1:0]     ch_cnt;
    logic [ACC_W-1:0]    acc;
    logic [BW-1:0]       thresh_q;
    logic [MAP_W-1:0]    map_q, map_nxt, out_map;
    logic [PC_W-1:0]     pc;

    logic accept, first_beat, last_beat, last_pix, ch_last;
    logic [BW-1:0] thr_cur;

    // Beat being retired into the accumulator (same cycle as acceptance, or one later when pipelined).
    logic              r_vld, r_last_beat, r_last_pix;
    logic [PC_W-1:0]   r_pc;
    logic [PIX_W-1:0]  r_pix;
    logic [BW-1:0]     r_thr;

    logic [ACC_W-1:0]  sum;
    logic              pix_bit, chan_done;

    bin_popcnt #(.WIN(WIN)) u_popcnt (
        .vec (~(i_act ^ i_wgt)),
        .cnt (pc)
    );

    assign accept     = i_valid && o_ready;
    assign first_beat = (beat_cnt == '0) && (pix_cnt == '0);
    assign last_beat  = (beat_cnt == BEAT_W'(IN_CH - 1));
    assign last_pix   = (pix_cnt == PIX_W'(MAP_W - 1));
    assign ch_last    = (ch_cnt == CH_W'(N_CH - 1));
    // The first beat of a channel sees the new threshold before it lands in thresh_q.
    assign thr_cur    = first_beat ? i_thresh : thresh_q;

`ifdef CONVACC_POPCNT_PIPE_EN
    // Register the popcount together with the beat's position so drain-cycle beats keep their own context.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld       <= 1'b0;
            r_pc        <= '0;
            r_last_beat <= 1'b0;
            r_last_pix  <= 1'b0;
            r_pix       <= '0;
            r_thr       <= '0;
        end else begin
            r_vld <= accept;
            if (accept) begin
                r_pc        <= pc;
                r_last_beat <= last_beat;
                r_last_pix  <= last_pix;
                r_pix       <= pix_cnt;
                r_thr       <= thr_cur;
            end
        end
    end
`else
    // Retire the accepted beat in the same cycle.
    always_comb begin
        r_vld       = accept;
        r_pc        = pc;
        r_last_beat = last_beat;
        r_last_pix  = last_pix;
        r_pix       = pix_cnt;
        r_thr       = thr_cur;
    end
`endif

    assign sum       = acc + ACC_W'(r_pc);
    assign pix_bit   = (32'(sum) >= 32'(r_thr));
    assign chan_done = r_vld && r_last_beat && r_last_pix;

    // Merge the finished pixel's bit into the map under construction.
    always_comb begin
        map_nxt = map_q;
        if (r_vld && r_last_beat) begin
            map_nxt[r_pix] = pix_bit;
        end
    end

    // Position of the next accepted beat, the channel threshold, and the emitted channel index.
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt <= '0;
            pix_cnt  <= '0;
            ch_cnt   <= '0;
            thresh_q <= '0;
        end else begin
            if (accept) begin
                if (first_beat) begin
                    thresh_q <= i_thresh;
                end
                if (last_beat) begin
                    beat_cnt <= '0;
                    pix_cnt  <= last_pix ? '0 : pix_cnt + PIX_W'(1);
                end else begin
                    beat_cnt <= beat_cnt + BEAT_W'(1);
                end
            end
            if (state == ST_EMIT && i_ready) begin
                ch_cnt <= ch_last ? '0 : ch_cnt + CH_W'(1);
            end
        end
    end

    // Accumulate pixel sums; snapshot the completed map so later beats cannot disturb an emitted word.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc     <= '0;
            map_q   <= '0;
            out_map <= '0;
        end else if (r_vld) begin
            acc   <= r_last_beat ? '0 : sum;
            map_q <= map_nxt;
            if (chan_done) begin
                out_map <= map_nxt;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: accumulate until a channel completes, then hold the word until it is taken.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (chan_done)   state_nxt = ST_EMIT;
                else if (accept) state_nxt = ST_ACCUM;
            end
            ST_ACCUM: begin
                if (chan_done)   state_nxt = ST_EMIT;
            end
            ST_EMIT: begin
                if (i_ready)     state_nxt = ch_last ? ST_IDLE : ST_ACCUM;
            end
            default:             state_nxt = ST_IDLE;
        endcase
    end

    assign o_ready = !reset && (state != ST_EMIT);
    assign o_valid = (state == ST_EMIT);
    assign o_map   = out_map;
    assign o_ch    = ch_cnt;
    assign o_last  = o_valid && ch_last;

endmodule

// File: tb/tb_convacc_bin_seq.sv
// Bench for convacc_bin_seq: a small instance for directed scenarios and a full-size instance for randomized traffic.
// Latency: expectations follow CONVACC_POPCNT_PIPE_EN (1 or 2 cycles to o_valid).
// Backpressure: i_ready held low and randomized; map word stability is checked.
module tb_convacc_bin_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int vectors     = 0;
    int miscompares = 0;

`ifdef CONVACC_POPCNT_PIPE_EN
    localparam logic [1:0] LAT_EXP = 2'b01;
`else
    localparam logic [1:0] LAT_EXP = 2'b11;
`endif

    // Small instance: N_CH=2, IN_CH=2, WIN=9, OUT_DIM=2.
    logic       s_ivalid, s_ordy, s_ovalid, s_iready, s_last;
    logic [8:0] s_act, s_wgt;
    logic [7:0] s_thr;
    logic [3:0] s_map;
    logic [0:0] s_ch;
    logic [8:0] s_act_a [8];
    logic [8:0] s_wgt_a [8];

    convacc_bin_seq #(.N_CH(2), .IN_CH(2), .WIN(9), .OUT_DIM(2), .BW(8)) dut_s (
        .clk(clk), .reset(reset), .i_valid(s_ivalid), .o_ready(s_ordy),
        .i_act(s_act), .i_wgt(s_wgt), .i_thresh(s_thr), .o_valid(s_ovalid),
        .i_ready(s_iready), .o_map(s_map), .o_ch(s_ch), .o_last(s_last)
    );

    // Large instance: N_CH=60, IN_CH=18, WIN=25, OUT_DIM=8.
    localparam int L_BEATS = 64 * 18;
    localparam int L_RUN   = 12;
    logic        l_ivalid, l_ordy, l_ovalid, l_iready, l_last;
    logic [24:0] l_act, l_wgt;
    logic [7:0]  l_thr;
    logic [63:0] l_map;
    logic [5:0]  l_ch;
    logic [24:0] la [L_BEATS];
    logic [24:0] lw [L_BEATS];
    logic [63:0] l_exp_q [$];

    convacc_bin_seq #(.N_CH(60), .IN_CH(18), .WIN(25), .OUT_DIM(8), .BW(8)) dut_l (
        .clk(clk), .reset(reset), .i_valid(l_ivalid), .o_ready(l_ordy),
        .i_act(l_act), .i_wgt(l_wgt), .i_thresh(l_thr), .o_valid(l_ovalid),
        .i_ready(l_iready), .o_map(l_map), .o_ch(l_ch), .o_last(l_last)
    );

    // Golden map for the small instance: pixel p sums matching bits over beats 2p and 2p+1.
    function automatic logic [3:0] s_model(input logic [7:0] thr);
        logic [3:0] m;
        int sum;
        for (int p = 0; p < 4; p++) begin
            sum = 0;
            for (int k = 0; k < 2; k++) sum += $countones(~(s_act_a[p*2+k] ^ s_wgt_a[p*2+k]));
            m[p] = (sum >= int'(thr));
        end
        return m;
    endfunction

    task automatic s_fill_random();
        for (int i = 0; i < 8; i++) begin
            s_act_a[i] = 9'($urandom);
            s_wgt_a[i] = 9'($urandom);
        end
    endtask

    // Present one beat and wait (bounded) until it is accepted.
    task automatic s_send_beat(input logic [8:0] a, input logic [8:0] w);
        int n;
        n = 0;
        s_act = a; s_wgt = w; s_ivalid = 1'b1;
        @(negedge clk);
        while (!s_ordy && n < 200) begin @(negedge clk); n++; end
        if (!s_ordy) begin
            vectors++; miscompares++;
            $display("FAIL s_beat_accept: o_ready stayed %b for %0d cycles, wanted 1", s_ordy, n);
        end
        @(posedge clk); #1;
        s_ivalid = 1'b0;
    endtask

    // Send a full channel from the beat arrays; report o_valid one and two cycles after the final beat.
    task automatic s_channel(input logic [7:0] thr, output logic [1:0] lat);
        s_thr = thr;
        for (int i = 0; i < 8; i++) s_send_beat(s_act_a[i], s_wgt_a[i]);
        lat[1] = s_ovalid;
        @(posedge clk); #1;
        lat[0] = s_ovalid;
    endtask

    // Wait (bounded) for a map word, capture it, and handshake it.
    task automatic s_take(output logic [3:0] m, output logic c, output logic l);
        int n;
        n = 0;
        @(negedge clk);
        while (!s_ovalid && n < 100) begin @(negedge clk); n++; end
        if (!s_ovalid) begin
            vectors++; miscompares++;
            $display("FAIL s_take_wait: o_valid stayed 0 for %0d cycles, wanted 1", n);
        end
        m = s_map; c = s_ch[0]; l = s_last;
        s_iready = 1'b1;
        @(posedge clk); #1;
        s_iready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors += 7;
        if (s_ovalid !== 1'b0) begin miscompares++; $display("FAIL reset_o_valid: got %b want 0", s_ovalid); end
        if (s_map !== 4'h0)    begin miscompares++; $display("FAIL reset_o_map: got %h want 0", s_map); end
        if (s_ch !== 1'b0)     begin miscompares++; $display("FAIL reset_o_ch: got %h want 0", s_ch); end
        if (s_last !== 1'b0)   begin miscompares++; $display("FAIL reset_o_last: got %b want 0", s_last); end
        if (s_ordy !== 1'b0)   begin miscompares++; $display("FAIL reset_o_ready: got %b want 0", s_ordy); end
        if (l_ovalid !== 1'b0) begin miscompares++; $display("FAIL reset_l_o_valid: got %b want 0", l_ovalid); end
        if (l_ordy !== 1'b0)   begin miscompares++; $display("FAIL reset_l_o_ready: got %b want 0", l_ordy); end
        reset = 1'b0;
        #1;
        vectors++;
        if (s_ordy !== 1'b1)   begin miscompares++; $display("FAIL idle_o_ready: got %b want 1", s_ordy); end
    endtask

    task automatic test_all_ones();
        logic [1:0] lat; logic [3:0] m; logic c, l;
        for (int ch = 0; ch < 2; ch++) begin
            for (int i = 0; i < 8; i++) begin s_act_a[i] = 9'h1FF; s_wgt_a[i] = 9'h1FF; end
            s_channel(8'd10, lat);
            s_take(m, c, l);
            vectors += 4;
            if (lat !== LAT_EXP)   begin miscompares++; $display("FAIL ones_latency ch%0d: got %b want %b", ch, lat, LAT_EXP); end
            if (m !== 4'hF)        begin miscompares++; $display("FAIL ones_map ch%0d: got %h want f", ch, m); end
            if (c !== ch[0])       begin miscompares++; $display("FAIL ones_ch ch%0d: got %b want %b", ch, c, ch[0]); end
            if (l !== (ch == 1))   begin miscompares++; $display("FAIL ones_last ch%0d: got %b want %b", ch, l, (ch == 1)); end
        end
    endtask

    task automatic test_threshold_mix();
        logic [1:0] lat; logic [3:0] m; logic c, l;
        logic [7:0] thr [2];
        logic [3:0] exp_m [2];
        thr[0] = 8'd18; thr[1] = 8'd19;
        exp_m[0] = 4'b0101; exp_m[1] = 4'b0000;
        for (int ch = 0; ch < 2; ch++) begin
            for (int p = 0; p < 4; p++) begin
                for (int k = 0; k < 2; k++) begin
                    s_act_a[p*2+k] = 9'h1FF;
                    s_wgt_a[p*2+k] = (k == 1 && (p % 2) == 1) ? 9'h1FE : 9'h1FF;
                end
            end
            s_channel(thr[ch], lat);
            s_take(m, c, l);
            vectors += 3;
            if (m !== exp_m[ch])   begin miscompares++; $display("FAIL mix_map ch%0d: got %b want %b", ch, m, exp_m[ch]); end
            if (c !== ch[0])       begin miscompares++; $display("FAIL mix_ch ch%0d: got %b want %b", ch, c, ch[0]); end
            if (l !== (ch == 1))   begin miscompares++; $display("FAIL mix_last ch%0d: got %b want %b", ch, l, (ch == 1)); end
        end
    endtask

    task automatic test_thresh_extremes();
        logic [1:0] lat; logic [3:0] m; logic c, l;
        // Threshold 0 with zero matching bits: every pixel still passes.
        for (int i = 0; i < 8; i++) begin s_act_a[i] = 9'($urandom); s_wgt_a[i] = ~s_act_a[i]; end
        s_channel(8'd0, lat);
        s_take(m, c, l);
        vectors += 2;
        if (m !== 4'hF)  begin miscompares++; $display("FAIL thr0_map: got %h want f", m); end
        if (c !== 1'b0)  begin miscompares++; $display("FAIL thr0_ch: got %b want 0", c); end
        // Threshold above the maximum sum: every pixel fails even with all bits matching.
        for (int i = 0; i < 8; i++) begin s_act_a[i] = 9'h1FF; s_wgt_a[i] = 9'h1FF; end
        s_channel(8'd255, lat);
        s_take(m, c, l);
        vectors += 2;
        if (m !== 4'h0)  begin miscompares++; $display("FAIL thr255_map: got %h want 0", m); end
        if (l !== 1'b1)  begin miscompares++; $display("FAIL thr255_last: got %b want 1", l); end
    endtask

    task automatic test_backpressure();
        logic [1:0] lat; logic [3:0] m, m0, m1; logic c, l;
        logic [7:0] thr0, thr1;
        s_fill_random();
        thr0 = 8'($urandom_range(0, 19));
        m0 = s_model(thr0);
        s_channel(thr0, lat);
        // Offer the next channel's first beat while the word is held.
        s_fill_random();
        thr1 = 8'($urandom_range(0, 19));
        m1 = s_model(thr1);
        s_thr = thr1; s_act = s_act_a[0]; s_wgt = s_wgt_a[0]; s_ivalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors += 3;
            if (s_ordy !== 1'b0)   begin miscompares++; $display("FAIL bp_o_ready cyc%0d: got %b want 0", i, s_ordy); end
            if (s_ovalid !== 1'b1) begin miscompares++; $display("FAIL bp_o_valid cyc%0d: got %b want 1", i, s_ovalid); end
            if (s_map !== m0)      begin miscompares++; $display("FAIL bp_o_map cyc%0d: got %h want %h", i, s_map, m0); end
        end
        s_take(m, c, l);
        vectors++;
        if (m !== m0) begin miscompares++; $display("FAIL bp_ch0_map: got %h want %h", m, m0); end
        s_channel(thr1, lat);
        s_take(m, c, l);
        vectors += 3;
        if (m !== m1)    begin miscompares++; $display("FAIL bp_ch1_map: got %h want %h", m, m1); end
        if (c !== 1'b1)  begin miscompares++; $display("FAIL bp_ch1_ch: got %b want 1", c); end
        if (l !== 1'b1)  begin miscompares++; $display("FAIL bp_ch1_last: got %b want 1", l); end
    endtask

    task automatic test_reset_mid();
        logic [1:0] lat; logic [3:0] m, em; logic c, l;
        logic [7:0] thr;
        s_fill_random();
        s_thr = 8'd3;
        for (int i = 0; i < 3; i++) s_send_beat(s_act_a[i], s_wgt_a[i]);
        reset = 1'b1;
        @(posedge clk); #1;
        vectors += 4;
        if (s_ovalid !== 1'b0) begin miscompares++; $display("FAIL rmid_o_valid: got %b want 0", s_ovalid); end
        if (s_map !== 4'h0)    begin miscompares++; $display("FAIL rmid_o_map: got %h want 0", s_map); end
        if (s_ch !== 1'b0)     begin miscompares++; $display("FAIL rmid_o_ch: got %h want 0", s_ch); end
        if (s_ordy !== 1'b0)   begin miscompares++; $display("FAIL rmid_o_ready: got %b want 0", s_ordy); end
        reset = 1'b0;
        for (int ch = 0; ch < 2; ch++) begin
            s_fill_random();
            thr = 8'($urandom_range(0, 19));
            em = s_model(thr);
            s_channel(thr, lat);
            s_take(m, c, l);
            vectors += 4;
            if (lat !== LAT_EXP)   begin miscompares++; $display("FAIL rmid_latency ch%0d: got %b want %b", ch, lat, LAT_EXP); end
            if (m !== em)          begin miscompares++; $display("FAIL rmid_map ch%0d: got %h want %h", ch, m, em); end
            if (c !== ch[0])       begin miscompares++; $display("FAIL rmid_ch ch%0d: got %b want %b", ch, c, ch[0]); end
            if (l !== (ch == 1))   begin miscompares++; $display("FAIL rmid_last ch%0d: got %b want %b", ch, l, (ch == 1)); end
        end
    endtask

    // Random beats with ~30% idle gaps; expected maps queued before the channel is sent.
    task automatic l_producer();
        int sum, n, r;
        logic [7:0] thr;
        logic [63:0] m;
        for (int c = 0; c < L_RUN; c++) begin
            r = $urandom_range(0, 9);
            thr = (r == 0) ? 8'd0 : (r == 1) ? 8'd255 : 8'($urandom_range(205, 245));
            for (int i = 0; i < L_BEATS; i++) begin la[i] = 25'($urandom); lw[i] = 25'($urandom); end
            for (int p = 0; p < 64; p++) begin
                sum = 0;
                for (int k = 0; k < 18; k++) sum += $countones(~(la[p*18+k] ^ lw[p*18+k]));
                m[p] = (sum >= int'(thr));
            end
            l_exp_q.push_back(m);
            l_thr = thr;
            for (int i = 0; i < L_BEATS; i++) begin
                while ($urandom_range(0, 9) < 3) begin l_ivalid = 1'b0; @(posedge clk); #1; end
                l_act = la[i]; l_wgt = lw[i]; l_ivalid = 1'b1;
                n = 0;
                @(negedge clk);
                while (!l_ordy && n < 2000) begin @(negedge clk); n++; end
                if (!l_ordy) begin
                    vectors++; miscompares++;
                    $display("FAIL rand_beat_accept: o_ready stayed 0 for %0d cycles, wanted 1", n);
                    l_ivalid = 1'b0;
                    return;
                end
                @(posedge clk); #1;
            end
            l_ivalid = 1'b0;
        end
    endtask

    // Random i_ready; checks word stability while stalled and every handshaken word against the queue.
    task automatic l_consumer();
        int got, cyc;
        logic hold;
        logic [63:0] held_map, em;
        got = 0; cyc = 0; hold = 1'b0; held_map = '0;
        while (got < L_RUN && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            if (hold) begin
                vectors++;
                if (l_ovalid !== 1'b1 || l_map !== held_map) begin
                    miscompares++;
                    $display("FAIL rand_stable: o_valid %b map %h, want 1 and %h", l_ovalid, l_map, held_map);
                end
            end
            l_iready = ($urandom_range(0, 9) >= 3);
            if (l_ovalid && l_iready) begin
                hold = 1'b0;
                vectors += 3;
                if (l_exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rand_map: got %h with no word expected", l_map);
                end else begin
                    em = l_exp_q.pop_front();
                    if (l_map !== em) begin miscompares++; $display("FAIL rand_map #%0d: got %h want %h", got, l_map, em); end
                end
                if (l_ch !== 6'(got % 60))         begin miscompares++; $display("FAIL rand_ch #%0d: got %0d want %0d", got, l_ch, got % 60); end
                if (l_last !== ((got % 60) == 59)) begin miscompares++; $display("FAIL rand_last #%0d: got %b want %b", got, l_last, (got % 60) == 59); end
                got++;
            end else if (l_ovalid) begin
                hold = 1'b1;
                held_map = l_map;
            end
        end
        @(posedge clk); #1;
        l_iready = 1'b0;
        if (got < L_RUN) begin
            vectors++; miscompares++;
            $display("FAIL rand_count: received %0d words, wanted %0d", got, L_RUN);
        end
    endtask

    task automatic test_random_large();
        fork
            l_producer();
            l_consumer();
        join
    endtask

    initial begin
        reset = 1'b1;
        s_ivalid = 1'b0; s_iready = 1'b0; s_act = '0; s_wgt = '0; s_thr = '0;
        l_ivalid = 1'b0; l_iready = 1'b0; l_act = '0; l_wgt = '0; l_thr = '0;
        test_reset();
        test_all_ones();
        test_threshold_mix();
        test_thresh_extremes();
        test_backpressure();
        test_reset_mid();
        test_random_large();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
